// File: rtl/word_gen_dispatch.sv
// Round-robin dispatcher from one word generator to NUM_UNITS crypt units, with end-of-packet drain.
// Optional macro WORD_GEN_DISPATCH_STATS_EN adds a per-packet dispatch count output.
module word_gen_dispatch #(
  parameter int unsigned CHAR_BITS    = 7,
  parameter int unsigned WORD_MAX_LEN = 8,
  parameter int unsigned NUM_UNITS    = 4
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic                              gen_empty,
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] gen_dout,
  input  logic [15:0]                       gen_pkt_id,
  input  logic [15:0]                       gen_word_id,
  input  logic [31:0]                       gen_id,
  input  logic                              gen_end,
  output logic                              gen_rd_en,
  input  logic [NUM_UNITS-1:0]              unit_full,
  input  logic [NUM_UNITS-1:0]              unit_idle,
  output logic [NUM_UNITS-1:0]              unit_wr_en,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0] unit_dout,
  output logic [15:0]                       unit_word_id,
  output logic [31:0]                       unit_gen_id,
  output logic                              pkt_done,
  output logic [15:0]                       pkt_done_id,
`ifdef WORD_GEN_DISPATCH_STATS_EN
  output logic [31:0]                       pkt_cand_count,
`endif
  output logic                              busy
);

  localparam int unsigned WordW = WORD_MAX_LEN * CHAR_BITS;
  localparam int unsigned PtrW  = $clog2(NUM_UNITS);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WordW-1:0]  dout_q, dout_d;
  logic [15:0]       word_id_q, word_id_d;
  logic [31:0]       gen_id_q, gen_id_d;
  logic [15:0]       end_id_q, end_id_d;

  logic [PtrW-1:0]   sel;
  logic              any_free;
  logic              dispatch;
  logic              load;
  int unsigned       idx;

  // First non-full unit at or after rr_ptr, wrapping.
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_UNITS) begin
        idx = idx - NUM_UNITS;
      end
      if (!any_free && !unit_full[idx[PtrW-1:0]]) begin
        sel      = idx[PtrW-1:0];
        any_free = 1'b1;
      end
    end
  end

  assign dispatch  = out_valid_q & any_free & ~rst;
  assign gen_rd_en = (state_q == StRun) & ~gen_empty & (~out_valid_q | dispatch) & ~rst;
  assign load      = gen_rd_en & ~gen_end;

  always_comb begin
    unit_wr_en = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      unit_wr_en[k] = dispatch && (sel == PtrW'(k));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    word_id_d   = word_id_q;
    gen_id_d    = gen_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      dout_d      = gen_dout;
      word_id_d   = gen_word_id;
      gen_id_d    = gen_id;
    end else if (dispatch) begin
      out_valid_d = 1'b0;
    end
    if (dispatch) begin
      rr_ptr_d = (sel == PtrW'(NUM_UNITS - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    end_id_d = end_id_q;
    unique case (state_q)
      StRun: begin
        // The end dummy is never loaded; it only records the packet id.
        if (gen_rd_en && gen_end) begin
          end_id_d = gen_pkt_id;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (!out_valid_q && (&unit_idle)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      dout_q      <= '0;
      word_id_q   <= '0;
      gen_id_q    <= '0;
      end_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      dout_q      <= dout_d;
      word_id_q   <= word_id_d;
      gen_id_q    <= gen_id_d;
      end_id_q    <= end_id_d;
    end
  end

  assign unit_dout    = dout_q;
  assign unit_word_id = word_id_q;
  assign unit_gen_id  = gen_id_q;
  assign pkt_done     = (state_q == StDone);
  assign pkt_done_id  = end_id_q;
  assign busy         = out_valid_q | (state_q != StRun);

`ifdef WORD_GEN_DISPATCH_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  // Count restarts in DONE; a dispatch in that cycle belongs to the next packet.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StDone) begin
      cnt_d = dispatch ? 32'd1 : 32'd0;
    end else if (dispatch && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cand_count = cnt_q;
`endif

endmodule

// File: tb/tb_word_gen_dispatch.sv
// Scoreboard bench for word_gen_dispatch: stimulus pushes expected writes/dones, a monitor pops and compares.
module tb_word_gen_dispatch;

  localparam int NU = 4;
  localparam int WW = 56;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          gen_empty;
  logic [WW-1:0] gen_dout;
  logic [15:0]   gen_pkt_id;
  logic [15:0]   gen_word_id;
  logic [31:0]   gen_id;
  logic          gen_end;
  logic          gen_rd_en;
  logic [NU-1:0] unit_full = '0;
  logic [NU-1:0] unit_idle = '1;
  logic [NU-1:0] unit_wr_en;
  logic [WW-1:0] unit_dout;
  logic [15:0]   unit_word_id;
  logic [31:0]   unit_gen_id;
  logic          pkt_done;
  logic [15:0]   pkt_done_id;
  logic          busy;
`ifdef WORD_GEN_DISPATCH_STATS_EN
  logic [31:0]   pkt_cand_count;
`endif

  always #5 CLK = ~CLK;

  word_gen_dispatch #(.CHAR_BITS(7), .WORD_MAX_LEN(8), .NUM_UNITS(NU)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .gen_empty    (gen_empty),
    .gen_dout     (gen_dout),
    .gen_pkt_id   (gen_pkt_id),
    .gen_word_id  (gen_word_id),
    .gen_id       (gen_id),
    .gen_end      (gen_end),
    .gen_rd_en    (gen_rd_en),
    .unit_full    (unit_full),
    .unit_idle    (unit_idle),
    .unit_wr_en   (unit_wr_en),
    .unit_dout    (unit_dout),
    .unit_word_id (unit_word_id),
    .unit_gen_id  (unit_gen_id),
    .pkt_done     (pkt_done),
    .pkt_done_id  (pkt_done_id),
`ifdef WORD_GEN_DISPATCH_STATS_EN
    .pkt_cand_count (pkt_cand_count),
`endif
    .busy         (busy)
  );

  typedef struct packed {logic [15:0] pkt; logic [31:0] id; logic is_end;} gen_t;
  typedef struct packed {logic [1:0] unit; logic [31:0] id;} wr_t;
  typedef struct packed {logic [15:0] id; logic [31:0] cnt;} done_t;

  gen_t  gq[$];
  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    wr_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [WW-1:0] dout_of(input logic [31:0] id);
    return {id, 24'hA5C3E1};
  endfunction

  function automatic logic [15:0] word_id_of(input logic [31:0] id);
    return id[15:0] ^ 16'h5A00;
  endfunction

  // Generator model: presents the queue head, pops it when a read is accepted at the edge.
  initial begin
    bit popped;
    gen_empty = 1'b1; gen_dout = '0; gen_pkt_id = '0; gen_word_id = '0; gen_id = '0; gen_end = 1'b0;
    forever begin
      @(negedge CLK);
      if (gq.size() > 0) begin
        gen_empty   = 1'b0;
        gen_dout    = dout_of(gq[0].id);
        gen_word_id = word_id_of(gq[0].id);
        gen_id      = gq[0].id;
        gen_pkt_id  = gq[0].pkt;
        gen_end     = gq[0].is_end;
      end else begin
        gen_empty = 1'b1;
        gen_end   = 1'b0;
      end
      #4;
      popped = gen_rd_en && !gen_empty;
      @(posedge CLK);
      if (popped && gq.size() > 0) gq.delete(0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    wr_t   e;
    done_t d;
    forever begin
      @(negedge CLK);
      #4;
      if (unit_wr_en != '0) begin
        wr_cyc.push_back(cyc);
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write wr_en=%b gen_id=%0d required no write", unit_wr_en, unit_gen_id);
        end else begin
          e = exp_wr.pop_front();
          if (unit_wr_en != (4'b0001 << e.unit) || unit_gen_id != e.id ||
              unit_dout != dout_of(e.id) || unit_word_id != word_id_of(e.id)) begin
            errors++;
            $display("FAIL write wr_en=%b gen_id=%0d dout=%h word_id=%h required wr_en=%b gen_id=%0d",
                     unit_wr_en, unit_gen_id, unit_dout, unit_word_id, 4'b0001 << e.unit, e.id);
          end
        end
      end
      if (pkt_done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done id=%h required no pkt_done", pkt_done_id);
        end else begin
          d = exp_done.pop_front();
          if (pkt_done_id != d.id) begin
            errors++;
            $display("FAIL done_id actual=%h required=%h", pkt_done_id, d.id);
          end
`ifdef WORD_GEN_DISPATCH_STATS_EN
          checks++;
          if (pkt_cand_count != d.cnt) begin
            errors++;
            $display("FAIL done_count actual=%0d required=%0d", pkt_cand_count, d.cnt);
          end
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cand(input logic [31:0] id, input logic [1:0] unit);
    gq.push_back('{pkt: 16'h0, id: id, is_end: 1'b0});
    exp_wr.push_back('{unit: unit, id: id});
  endtask

  task automatic endp(input logic [15:0] pkt);
    gq.push_back('{pkt: pkt, id: 32'h0, is_end: 1'b1});
  endtask

  task automatic exp_pkt(input logic [15:0] id, input logic [31:0] cnt);
    exp_done.push_back('{id: id, cnt: cnt});
  endtask

  task automatic wait_clear(input string name, input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0 || gq.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout pending_writes=%0d pending_dones=%0d required 0",
               name, exp_wr.size(), exp_done.size());
    end
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    #4;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rd_en", 64'(gen_rd_en), 64'd0);
    chk("reset_wr_en", 64'(unit_wr_en), 64'd0);
    chk("reset_done", 64'(pkt_done), 64'd0);
    chk("reset_done_id", 64'(pkt_done_id), 64'd0);
    chk("reset_dout", 64'(unit_dout), 64'd0);
    chk("reset_gen_id", 64'(unit_gen_id), 64'd0);
    chk("reset_word_id", 64'(unit_word_id), 64'd0);

    // Throughput: 8 candidates round-robin, one write per cycle.
    @(negedge CLK);
    wr_cyc.delete();
    for (int i = 0; i < 8; i++) cand(32'(i), 2'(i % 4));
    endp(16'h0012);
    exp_pkt(16'h0012, 32'd8);
    wait_clear("throughput", 60);
    chk("throughput_writes", 64'(wr_cyc.size()), 64'd8);
    if (wr_cyc.size() == 8) chk("throughput_span", 64'(wr_cyc[7] - wr_cyc[0]), 64'd7);

    // Skip full units: move rr_ptr to 1, then units 1 and 2 full.
    cand(32'd20, 2'd0);
    wait_clear("rr_setup", 30);
    unit_full = 4'b0110;
    cand(32'd21, 2'd3);
    cand(32'd22, 2'd0);
    cand(32'd23, 2'd3);
    wait_clear("skip_full", 30);
    unit_full = 4'b0000;

    // Backpressure: everything full with a candidate held and another waiting.
    @(negedge CLK);
    unit_full = 4'b1111;
    cand(32'd30, 2'd0);
    cand(32'd31, 2'd1);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #4;
      chk("bp_rd_en", 64'(gen_rd_en), 64'd0);
      chk("bp_wr_en", 64'(unit_wr_en), 64'd0);
      chk("bp_held", 64'(unit_gen_id), 64'd30);
    end
    @(negedge CLK);
    unit_full = 4'b0000;
    wait_clear("backpressure", 30);

    // Drain wait with unit 2 busy, followed by an empty packet in the generator queue.
    unit_idle = 4'b1011;
    endp(16'h0033);
    endp(16'h0005);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #4;
      chk("drain_rd_en", 64'(gen_rd_en), 64'd0);
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_no_done", 64'(pkt_done), 64'd0);
    end
    @(negedge CLK);
    exp_pkt(16'h0033, 32'd6);
    exp_pkt(16'h0005, 32'd0);
    unit_idle = 4'b1111;
    wait_clear("drain_empty", 30);

    // Reset while draining: no done, pointer back to unit 0.
    cand(32'd50, 2'd2);
    wait_clear("pre_reset", 30);
    unit_idle = 4'b0000;
    endp(16'h0077);
    repeat (4) @(negedge CLK);
    #4;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    #4;
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_done", 64'(pkt_done), 64'd0);
    @(negedge CLK);
    unit_idle = 4'b1111;
    repeat (3) @(negedge CLK);
    cand(32'd60, 2'd0);
    endp(16'h0078);
    exp_pkt(16'h0078, 32'd1);
    wait_clear("post_reset_pkt", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
